// File: rtl/squeezer.sv
// Sponge squeeze stage: streams the rate portion of each permutation output
// as 32-bit words, MSB word first, and requests more permutations as needed.
module squeezer #(
  parameter int RATE  = 1088,
  parameter int WORDS = RATE / 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     num_words,
  input  logic [RATE-1:0] state_in,
  input  logic            state_valid,
  output logic            state_ack,
  output logic            squeeze_req,
  output logic [31:0]     out,
  output logic            out_valid,
  input  logic            out_ack,
  output logic            busy,
  output logic            done
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BLK, EMIT, DONE} state_t;

  state_t          state, next;
  logic [RATE-1:0] blk, blk_sh;
  logic [15:0]     remaining;
  logic [IW-1:0]   idx;
  logic [31:0]     word;
  logic            load, take, last, blk_end;

  assign blk_sh  = blk << 32;
  assign last    = (remaining == 16'd1);
  assign blk_end = (idx == IW'(WORDS - 1));

  always_comb begin
    next = state;
    load = 1'b0;
    take = 1'b0;
    case (state)
      IDLE:     if (start) next = (num_words == 16'd0) ? DONE : WAIT_BLK;
      WAIT_BLK: if (state_valid) begin
                  load = 1'b1;
                  next = EMIT;
                end
      EMIT:     if (out_ack) begin
                  take = 1'b1;
                  if (last)         next = DONE;
                  else if (blk_end) next = WAIT_BLK;
                end
      DONE:     next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      blk         <= '0;
      remaining   <= '0;
      idx         <= '0;
      word        <= '0;
      state_ack   <= 1'b0;
      squeeze_req <= 1'b0;
    end else begin
      state       <= next;
      state_ack   <= load;
      squeeze_req <= take && !last && blk_end;
      if (state == IDLE && start) remaining <= num_words;
      if (load) begin
        blk  <= state_in;
        idx  <= '0;
        word <= state_in[RATE-1 -: 32];
      end
      if (take) begin
        blk       <= blk_sh;
        remaining <= remaining - 16'd1;
        idx       <= idx + IW'(1);
        // Output register only advances while staying in EMIT, so out holds
        // the last word through WAIT_BLK and DONE.
        if (!last && !blk_end) word <= blk_sh[RATE-1 -: 32];
      end
    end
  end

  assign out       = word;
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_squeezer.sv
// Directed bench for squeezer: single-word, full block, block refill,
// backpressure, mid-squeeze reset and zero-length squeezes.
module tb_squeezer;
  localparam int RATE  = 1088;
  localparam int WORDS = 34;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [15:0]     num_words = '0;
  logic [RATE-1:0] state_in = '0;
  logic            state_valid = 1'b0;
  logic            state_ack, squeeze_req, out_valid, busy, done;
  logic [31:0]     out;
  logic            out_ack = 1'b0;

  int tests = 0, fails = 0;
  int ack_cnt = 0, sq_cnt = 0, ov_cnt = 0, cap_n = 0;
  logic [31:0] cap [0:255];
  int b_ack, b_sq, b_ov, b_cap, n;

  squeezer #(.RATE(RATE), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .state_in(state_in), .state_valid(state_valid), .state_ack(state_ack),
    .squeeze_req(squeeze_req), .out(out), .out_valid(out_valid),
    .out_ack(out_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pulse counters and accepted-word log, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (state_ack)   ack_cnt++;
      if (squeeze_req) sq_cnt++;
      if (out_valid)   ov_cnt++;
      if (out_valid && out_ack && cap_n < 256) begin
        cap[cap_n] = out;
        cap_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_ack = ack_cnt; b_sq = sq_cnt; b_ov = ov_cnt; b_cap = cap_n;
  endtask

  // Ticks until done; the cycle count since the call is checked.
  task automatic wait_done(input string tag, input int exp_n);
    int k;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      k++;
      if (done) break;
    end
    chk(tag, k, exp_n);
  endtask

  function automatic logic [RATE-1:0] mkblk(input logic [31:0] w0);
    logic [RATE-1:0] b;
    b = '0;
    for (int k = 0; k < WORDS; k++) b[RATE-1-32*k -: 32] = w0 + 32'(k);
    return b;
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_out", out, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state_ack", state_ack, 1'b0);
    chk("rst_squeeze_req", squeeze_req, 1'b0);
    reset = 1'b0;
    tick();

    // Single word, ack tied high
    state_in = mkblk(32'hDEADBEEF); state_valid = 1'b1; out_ack = 1'b1;
    num_words = 16'd1; start = 1'b1; snap();
    tick(); start = 1'b0;
    chk("w1_busy_n1", busy, 1'b1);
    chk("w1_ov_n1", out_valid, 1'b0);
    tick();
    chk("w1_ov_n2", out_valid, 1'b1);
    chk("w1_out_n2", out, 32'hDEADBEEF);
    chk("w1_ack_n2", state_ack, 1'b1);
    tick();
    chk("w1_done_n3", done, 1'b1);
    chk("w1_ov_n3", out_valid, 1'b0);
    chk("w1_out_hold", out, 32'hDEADBEEF);
    tick();
    chk("w1_done_n4", done, 1'b0);
    chk("w1_busy_n4", busy, 1'b0);
    chk("w1_ack_cnt", ack_cnt - b_ack, 1);
    chk("w1_sq_cnt", sq_cnt - b_sq, 0);
    chk("w1_ov_cnt", ov_cnt - b_ov, 1);
    state_valid = 1'b0;

    // Full block of 34 words, ascending
    state_in = mkblk(32'h0); state_valid = 1'b1;
    num_words = 16'd34; start = 1'b1; snap();
    wait_done("w34_cycles", 36);
    start = 1'b0;
    for (int k = 0; k < WORDS; k++) chk($sformatf("w34_word%0d", k), cap[b_cap+k], 32'(k));
    chk("w34_cap_n", cap_n - b_cap, 34);
    chk("w34_sq_cnt", sq_cnt - b_sq, 0);
    chk("w34_ack_cnt", ack_cnt - b_ack, 1);
    tick();
    chk("w34_idle", busy, 1'b0);

    // 35 words across two blocks
    state_in = mkblk(32'h0); state_valid = 1'b1;
    num_words = 16'd35; start = 1'b1; snap();
    tick(); start = 1'b0;
    tick(); state_valid = 1'b0; state_in = mkblk(32'hCAFEF00D);
    n = 2;
    for (int i = 0; i < 100; i++) begin
      tick(); n++;
      if (squeeze_req) break;
    end
    chk("w35_sq_cycle", n, 36);
    chk("w35_sq_ov", out_valid, 1'b0);
    chk("w35_sq_busy", busy, 1'b1);
    state_valid = 1'b1;
    wait_done("w35_done", 2);
    chk("w35_word33", cap[b_cap+33], 32'd33);
    chk("w35_word34", cap[b_cap+34], 32'hCAFEF00D);
    chk("w35_cap_n", cap_n - b_cap, 35);
    chk("w35_ack_cnt", ack_cnt - b_ack, 2);
    chk("w35_sq_cnt", sq_cnt - b_sq, 1);
    state_valid = 1'b0;
    tick();

    // Backpressure: ack low for 10 cycles
    state_in = mkblk(32'hA0); state_valid = 1'b1; out_ack = 1'b0;
    num_words = 16'd3; start = 1'b1; snap();
    tick(); start = 1'b0;
    tick(); state_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_ov%0d", i), out_valid, 1'b1);
      chk($sformatf("bp_out%0d", i), out, 32'hA0);
      if (i < 9) tick();
    end
    out_ack = 1'b1;
    wait_done("bp_done", 3);
    chk("bp_w0", cap[b_cap], 32'hA0);
    chk("bp_w2", cap[b_cap+2], 32'hA2);
    tick();

    // Reset mid-EMIT at word 5, then a fresh 2-word squeeze
    state_in = mkblk(32'h0); state_valid = 1'b1;
    num_words = 16'd34; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("mr_word5", out, 32'd5);
    reset = 1'b1;
    tick();
    chk("mr_ov", out_valid, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_out", out, 32'h0);
    reset = 1'b0;
    state_in = mkblk(32'h1000); num_words = 16'd2; start = 1'b1; snap();
    wait_done("mr_done", 4);
    start = 1'b0;
    chk("mr_w0", cap[b_cap], 32'h1000);
    chk("mr_w1", cap[b_cap+1], 32'h1001);
    chk("mr_ov_cnt", ov_cnt - b_ov, 2);
    state_valid = 1'b0;
    tick();

    // Zero-length squeeze ignores a valid block
    state_valid = 1'b1; num_words = 16'd0; start = 1'b1; snap();
    tick(); start = 1'b0;
    chk("z_done", done, 1'b1);
    chk("z_ov", out_valid, 1'b0);
    tick();
    chk("z_done_end", done, 1'b0);
    chk("z_busy_end", busy, 1'b0);
    tick();
    chk("z_ack_cnt", ack_cnt - b_ack, 0);
    chk("z_sq_cnt", sq_cnt - b_sq, 0);
    chk("z_ov_cnt", ov_cnt - b_ov, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/squeezer.md
SQUEEZER -- requirements
Module: squeezer

Interface
REQ-001 SHALL have parameter RATE, default 1088, the sponge rate in bits; it SHALL be a multiple of 32.
REQ-002 SHALL have parameter WORDS, default RATE/32 (34), the number of 32-bit words per rate block.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begins a squeeze of num_words words; sampled only in IDLE.
REQ-006 num_words  input  16  number of 32-bit output words requested, latched with start.
REQ-007 state_in  input  RATE  rate portion of the permutation output; bits [RATE-1:RATE-32] hold word 0.
REQ-008 state_valid  input  1  from the permutation: state_in holds a valid block.
REQ-009 state_ack  output  1  to the permutation: one-cycle pulse meaning the block has been latched.
REQ-010 squeeze_req  output  1  to the permutation: one-cycle pulse requesting one more permutation of the current state.
REQ-011 out  output  32  output word to the user.
REQ-012 out_valid  output  1  out holds a valid word.
REQ-013 out_ack  input  1  user consumes out; it has effect only while out_valid=1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse marking the end of the squeeze.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT_BLK, EMIT and DONE.
REQ-017 IDLE: on start=1, SHALL latch num_words into the remaining counter.
- If num_words=0, SHALL go to DONE.
- Otherwise SHALL go to WAIT_BLK.
- SHALL NOT pulse squeeze_req; the first block comes from the absorb path.
REQ-018 WAIT_BLK: on state_valid=1, SHALL load state_in into the RATE-bit shift buffer, clear the word index and go to EMIT.
REQ-019 state_ack SHALL be a registered pulse, high for exactly the one cycle after the load cycle.
REQ-020 EMIT: out_valid=1 and out=buffer[RATE-1:RATE-32]; both SHALL be held stable until out_ack=1.
REQ-021 On out_ack=1 in EMIT, in the same cycle:
- shift the buffer left by 32;
- decrement the remaining counter;
- increment the word index.
REQ-022 If remaining reaches 0 on that ack, SHALL go to DONE; this takes priority over the block-exhausted rule.
REQ-023 Otherwise, if the acked word was index WORDS-1, SHALL go to WAIT_BLK and pulse squeeze_req (registered) for exactly one cycle.
REQ-024 Word order SHALL be MSB-first across the block: word k = state_in[RATE-1-32k : RATE-32-32k].
REQ-025 Maximum throughput SHALL be one word per cycle while out_ack is held high within a block.
REQ-026 Latency: with start at cycle N and state_valid already high, out_valid SHALL first be high at cycle N+2.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 out_valid SHALL be 0 in IDLE, WAIT_BLK and DONE.
REQ-029 out SHALL hold its last value while out_valid=0.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 state_valid outside WAIT_BLK SHALL be ignored.
REQ-032 out_ack while out_valid=0 SHALL be ignored.

Reset
REQ-033 On reset=1, regardless of state, the next cycle SHALL show:
- FSM=IDLE;
- out=0, out_valid=0, state_ack=0, squeeze_req=0, busy=0, done=0;
- buffer, remaining counter and word index cleared.
REQ-034 After reset deasserts, the first start SHALL behave as from power-up; no partial squeeze SHALL resume.

Verification
REQ-035 num_words=1, block word0=0xDEADBEEF, out_ack tied high -> single out_valid cycle with out=0xDEADBEEF; state_ack pulse once; done pulse the next cycle; squeeze_req never asserted.
REQ-036 num_words=34, block words 0x00000000..0x00000021 -> 34 consecutive words in ascending order; no squeeze_req; done after the 34th ack.
REQ-037 num_words=35 -> squeeze_req single pulse after the 34th ack; second block with word0=0xCAFEF00D -> 35th word=0xCAFEF00D, then done; state_ack pulsed exactly twice.
REQ-038 out_ack held low 10 cycles in EMIT -> out_valid=1 and out unchanged all 10 cycles; remaining unchanged.
REQ-039 reset pulsed mid-EMIT at word 5 of 34 -> next cycle out_valid=0, busy=0; a new start with num_words=2 emits words 0 and 1 of the newly presented block.
REQ-040 num_words=0 -> done pulse on the cycle after the start cycle; no state_ack, no squeeze_req, no out_valid.
